// File: rtl/ugemm_rate_pkg.sv
// Shared types and helpers for the rate-coded (unary) multiplier blocks.
// Holds the FSM state type, the Sobol trailing-ones helper and window sizing.
package ugemm_rate_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of consecutive ones starting at bit 0, limited to the low 'width' bits.
   function automatic int trailing_ones(input logic [31:0] v, input int width);
      int   n;
      logic run_flag;
      n        = 0;
      run_flag = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i < width && run_flag && v[i]) n++;
         else run_flag = 1'b0;
      end
      return n;
   endfunction

   function automatic int count_width(input int cycle_log);
      return cycle_log + 1;
   endfunction

   function automatic int window_len(input int cycle_log);
      return 1 << cycle_log;
   endfunction

endpackage

// File: rtl/sobol_gen.sv
// One-dimensional Sobol generator: on each enabled cycle flips bit (WIDTH-1-t) of the
// state, t being the trailing-ones count of the index; synchronous clear restarts it.
module sobol_gen
   import ugemm_rate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] sobolSeq
);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] w_mask;
   int               w_t;

   // An all-ones index (t == WIDTH) flips nothing instead of shifting out of range.
   always_comb begin
      w_t    = trailing_ones(32'(r_c), WIDTH);
      w_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_t == i) w_mask[WIDTH-1-i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_x <= '0;
         r_c <= '0;
      end else if (enable) begin
         r_x <= r_x ^ w_mask;
         r_c <= r_c + WIDTH'(1);
      end
   end

   assign sobolSeq = r_x;

endmodule

// File: rtl/mul_border_lanes.sv
// Border multiplier for the rate-coded systolic array: one shared input bitstream,
// LANES weight bitstreams, per-lane product counts over a 2^CYCLE_LOG window.
module mul_border_lanes
   import ugemm_rate_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LANES     = 4,
   parameter int CYCLE_LOG = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_start,
   input  logic                             i_bipolar,
   input  logic [WIDTH-1:0]                 i_data_i,
   input  logic [LANES*WIDTH-1:0]           i_data_w,
   output logic                             o_busy,
   output logic [WIDTH-1:0]                 o_randW,
   output logic [WIDTH-1:0]                 o_randW_inv,
   output logic                             o_bit_i,
   output logic [LANES-1:0]                 o_bit,
   output logic                             o_valid,
   output logic                             o_done,
   output logic [LANES*(CYCLE_LOG+1)-1:0]   o_count
);

   localparam int CW = count_width(CYCLE_LOG);

   state_t                   r_state;
   logic                     r_bipolar;
   logic [WIDTH-1:0]         r_di;
   logic [LANES*WIDTH-1:0]   r_dw;
   logic [CYCLE_LOG-1:0]     r_phase;
   logic                     r_busy;
   logic                     r_bit_i;
   logic [LANES-1:0]         r_bit;
   logic                     r_valid;
   logic                     r_done;

   logic                     w_accept;
   logic                     w_run;
   logic                     w_last;
   logic [WIDTH-1:0]         w_rand_i;
   logic [WIDTH-1:0]         w_rand_w;
   logic [WIDTH-1:0]         w_rand_winv;
   logic                     w_bit_i;
   logic [LANES-1:0]         w_prod;

   assign w_accept = i_start && (r_state != RUN);
   assign w_run    = (r_state == RUN);
   assign w_last   = w_run && (r_phase == '1);
   assign w_bit_i  = r_di > w_rand_i;

   // The weight generators split the cycles: one steps on input ones, the other on zeros.
   sobol_gen #(.WIDTH(WIDTH)) u_sobol_i (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_accept),
      .enable   (w_run),
      .sobolSeq (w_rand_i)
   );

   sobol_gen #(.WIDTH(WIDTH)) u_sobol_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_accept),
      .enable   (w_run && w_bit_i),
      .sobolSeq (w_rand_w)
   );

   sobol_gen #(.WIDTH(WIDTH)) u_sobol_winv (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_accept),
      .enable   (w_run && !w_bit_i),
      .sobolSeq (w_rand_winv)
   );

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0] w_wt;
         logic             w_bit_w;
         logic             w_bit_winv;
         logic [CW-1:0]    r_cnt;

         assign w_wt       = r_dw[gi*WIDTH +: WIDTH];
         assign w_bit_w    = w_wt > w_rand_w;
         assign w_bit_winv = w_wt <= w_rand_winv;
         assign w_prod[gi] = r_bipolar ? ((w_bit_i & w_bit_w) | (~w_bit_i & w_bit_winv))
                                       : (w_bit_i & w_bit_w);

         always_ff @(posedge clk) begin
            if (!rst_n || w_accept) r_cnt <= '0;
            else if (w_run && w_prod[gi]) r_cnt <= r_cnt + CW'(1);
         end

         assign o_count[gi*CW +: CW] = r_cnt;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bipolar <= 1'b0;
         r_di      <= '0;
         r_dw      <= '0;
         r_phase   <= '0;
         r_busy    <= 1'b0;
         r_bit_i   <= 1'b0;
         r_bit     <= '0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            RUN: begin
               r_bit   <= w_prod;
               r_bit_i <= w_bit_i;
               r_valid <= 1'b1;
               r_phase <= r_phase + CYCLE_LOG'(1);
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
               r_valid <= 1'b0;
               if (w_accept) begin
                  r_state   <= RUN;
                  r_bipolar <= i_bipolar;
                  r_di      <= i_data_i;
                  r_dw      <= i_data_w;
                  r_phase   <= '0;
                  r_busy    <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_randW     = w_rand_w;
   assign o_randW_inv = w_rand_winv;
   assign o_bit_i     = r_bit_i;
   assign o_bit       = r_bit;
   assign o_valid     = r_valid;
   assign o_done      = r_done;

endmodule

// File: tb/tb_mul_border_lanes.sv
// Self-checking bench for mul_border_lanes: job table, per-cycle bit scoreboard
// built from an independent Sobol model, plus back-to-back and abort sequences.
module tb_mul_border_lanes;

   localparam int W   = 8;
   localparam int L   = 4;
   localparam int CL  = 8;
   localparam int CW  = CL + 1;
   localparam int WIN = 1 << CL;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                i_start;
   logic                i_bipolar;
   logic [W-1:0]        i_data_i;
   logic [L*W-1:0]      i_data_w;
   logic                o_busy;
   logic [W-1:0]        o_randW;
   logic [W-1:0]        o_randW_inv;
   logic                o_bit_i;
   logic [L-1:0]        o_bit;
   logic                o_valid;
   logic                o_done;
   logic [L*CW-1:0]     o_count;

   always #5 clk = ~clk;

   mul_border_lanes #(.WIDTH(W), .LANES(L), .CYCLE_LOG(CL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_bipolar   (i_bipolar),
      .i_data_i    (i_data_i),
      .i_data_w    (i_data_w),
      .o_busy      (o_busy),
      .o_randW     (o_randW),
      .o_randW_inv (o_randW_inv),
      .o_bit_i     (o_bit_i),
      .o_bit       (o_bit),
      .o_valid     (o_valid),
      .o_done      (o_done),
      .o_count     (o_count)
   );

   typedef struct {
      bit          bip;
      logic [7:0]  di;
      logic [31:0] dw;
      bit [3:0]    spec_mask;
      int          spec [4];
      int          exp_bi;
   } vec_t;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   seq [256];
   logic [4:0]   sb [$];
   int           mcount [4];
   vec_t         tbl [5];
   logic [7:0]   rng_exp [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit bip, input logic [7:0] di, input logic [31:0] dw,
                               input bit [3:0] m, input int s0, input int s1, input int s2,
                               input int s3, input int ebi);
      vec_t v;
      v.bip = bip; v.di = di; v.dw = dw; v.spec_mask = m;
      v.spec[0] = s0; v.spec[1] = s1; v.spec[2] = s2; v.spec[3] = s3;
      v.exp_bi = ebi;
      return v;
   endfunction

   // Sobol with these direction numbers is the bit-reversed Gray code of the index.
   task automatic build_seq();
      for (int n = 0; n < 256; n++) begin
         logic [7:0] g, r;
         g = 8'(n ^ (n >> 1));
         for (int b = 0; b < 8; b++) r[7-b] = g[b];
         seq[n] = r;
      end
   endtask

   task automatic model_push(input vec_t v);
      int ci, cw, cwi;
      logic bi;
      logic [3:0] pr;
      ci = 0; cw = 0; cwi = 0;
      for (int l = 0; l < 4; l++) mcount[l] = 0;
      for (int c = 0; c < WIN; c++) begin
         bi = v.di > seq[ci];
         for (int l = 0; l < 4; l++) begin
            logic [7:0] wv;
            logic bw, bwi;
            wv  = v.dw[l*8 +: 8];
            bw  = wv > seq[cw];
            bwi = wv <= seq[cwi];
            pr[l] = v.bip ? ((bi & bw) | (~bi & bwi)) : (bi & bw);
            mcount[l] += int'(pr[l]);
         end
         sb.push_back({bi, pr});
         ci++;
         if (bi) cw++; else cwi++;
      end
   endtask

   task automatic accept(input vec_t v);
      i_start   = 1'b1;
      i_bipolar = v.bip;
      i_data_i  = v.di;
      i_data_w  = v.dw;
      model_push(v);
      @(posedge clk);
      #1 i_start = 1'b0;
   endtask

   task automatic watch(input vec_t v, input bit chain, input vec_t nxt,
                        input bit mid_pulse, input bit chk_rng, input bit chk_w0);
      int vcnt, bcnt, done_k, first_v, bi_cnt, w_bad;
      logic [4:0] e;
      vcnt = 0; bcnt = 0; done_k = -1; first_v = -1; bi_cnt = 0; w_bad = 0;
      for (int k = 1; k <= WIN + 10; k++) begin
         @(negedge clk);
         if (chk_rng && k <= 5) chk("rng_order", 64'(o_randW), 64'(rng_exp[k-1]));
         if (o_randW != 8'd0) w_bad++;
         if (o_busy) bcnt++;
         if (mid_pulse && k == 50) begin
            i_start  = 1'b1;
            i_data_i = 8'h5A;
            i_data_w = $urandom;
         end
         if (mid_pulse && k == 51) i_start = 1'b0;
         if (o_valid) begin
            vcnt++;
            if (first_v < 0) first_v = k;
            if (o_bit_i) bi_cnt++;
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'(1), 64'(0));
            end else begin
               e = sb.pop_front();
               chk("bits", 64'({o_bit_i, o_bit}), 64'(e));
            end
         end
         if (o_done) begin
            done_k = k;
            for (int l = 0; l < 4; l++) begin
               chk("count_model", 64'(o_count[l*CW +: CW]), 64'(mcount[l]));
               if (v.spec_mask[l]) chk("count_spec", 64'(o_count[l*CW +: CW]), 64'(v.spec[l]));
            end
            if (chain) accept(nxt);
            break;
         end
      end
      chk("done_latency", 64'(done_k), 64'(WIN + 1));
      chk("valid_cycles", 64'(vcnt), 64'(WIN));
      chk("first_valid", 64'(first_v), 64'(2));
      chk("busy_cycles", 64'(bcnt), 64'(WIN));
      if (v.exp_bi >= 0) chk("bit_i_ones", 64'(bi_cnt), 64'(v.exp_bi));
      if (chk_w0) chk("randW_zero", 64'(w_bad), 64'(0));
      $display("job bip=%0d di=%0d dw=%08h done_k=%0d valid=%0d counts=%0d,%0d,%0d,%0d",
               v.bip, v.di, v.dw, done_k, vcnt, o_count[0*CW +: CW], o_count[1*CW +: CW],
               o_count[2*CW +: CW], o_count[3*CW +: CW]);
   endtask

   initial begin
      vec_t dummy;
      bit   done_seen;
      build_seq();
      rng_exp[0] = 8'd0; rng_exp[1] = 8'd128; rng_exp[2] = 8'd192;
      rng_exp[3] = 8'd64; rng_exp[4] = 8'd96;
      tbl[0] = mk(1'b0, 8'd255, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 0, -1);
      tbl[1] = mk(1'b0, 8'd128, 32'hFFFF_FFFF, 4'b1111, 128, 128, 128, 128, 128);
      tbl[2] = mk(1'b0, 8'd200, {8'd255, 8'd255, 8'd255, 8'd0}, 4'b0001, 0, 0, 0, 0, 200);
      tbl[3] = mk(1'b1, 8'd0, {8'd128, 8'd255, 8'd0, 8'd64}, 4'b1111, 192, 256, 1, 128, 0);
      tbl[4] = mk(1'b1, 8'd100, {8'd150, 8'd50, 8'd200, 8'd10}, 4'b0000, 0, 0, 0, 0, 100);
      dummy  = tbl[0];

      rst_n = 1'b0; i_start = 1'b0; i_bipolar = 1'b0; i_data_i = '0; i_data_w = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({o_busy, o_randW, o_randW_inv, o_bit_i, o_bit, o_valid, o_done,
                                o_count}), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         accept(tbl[i]);
         watch(tbl[i], 1'b0, dummy, 1'b0, i == 0, i == 3);
      end

      // Back-to-back: second start in the DONE cycle, stray start mid-run in the first job.
      @(negedge clk);
      accept(tbl[4]);
      watch(tbl[4], 1'b1, tbl[2], 1'b1, 1'b0, 1'b0);
      watch(tbl[2], 1'b0, dummy, 1'b0, 1'b0, 1'b0);

      // Abort at RUN cycle 100 with a one-cycle reset pulse.
      @(negedge clk);
      accept(tbl[3]);
      done_seen = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (o_done) done_seen = 1'b1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_outputs", 64'({o_busy, o_randW, o_randW_inv, o_bit_i, o_bit, o_valid, o_done,
                                o_count}), 64'(0));
      sb.delete();
      repeat (WIN + 5) begin
         @(negedge clk);
         if (o_done || o_valid || o_busy) done_seen = 1'b1;
      end
      chk("abort_quiet", 64'(done_seen), 64'(0));
      accept(tbl[1]);
      watch(tbl[1], 1'b0, dummy, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
